// File: rtl/io_port_pkg.sv
// rtl/io_port_pkg.sv - shared io_op bit indices and printer state encodings
package io_port_pkg;

    localparam int IO_INP = 3;
    localparam int IO_OUT = 2;
    localparam int IO_SKI = 1;
    localparam int IO_SKO = 0;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_SEND = 2'd1,
        P_BUSY = 2'd2
    } prn_state_t;

endpackage

// File: rtl/io_port.sv
// rtl/io_port.sv - programmed-I/O port: INPR/OUTR, FGI/FGO, INP/OUT/SKI/SKO
module io_port
    import io_port_pkg::*;
#(
    parameter int PRN_HOLDOFF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_exec,
    input  logic [3:0] io_op,
    input  logic [7:0] ac_low,
    output logic [7:0] inpr,
    output logic       ld_ac_inpr,
    output logic       skip,
    output logic       fgi,
    output logic       fgo,
    input  logic [7:0] kbd_data,
    input  logic       kbd_valid,
    output logic       kbd_ready,
    output logic [7:0] prn_data,
    output logic       prn_valid,
    input  logic       prn_ready
);

    prn_state_t state, state_nxt;
    logic [7:0] outr, outr_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       fgo_nxt;
    logic       kbd_xfer;
    logic       inp_cmd;
    logic       out_cmd;

    assign kbd_ready  = ~fgi;
    assign kbd_xfer   = kbd_valid & ~fgi;
    assign inp_cmd    = io_exec & io_op[IO_INP];
    assign out_cmd    = io_exec & io_op[IO_OUT];
    assign ld_ac_inpr = inp_cmd;
    assign skip       = io_exec & ((io_op[IO_SKI] & fgi) | (io_op[IO_SKO] & fgo));
    assign prn_data   = outr;

    // Keyboard side: a transfer at the same edge as INP wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inpr <= 8'h00;
            fgi  <= 1'b0;
        end else if (kbd_xfer) begin
            inpr <= kbd_data;
            fgi  <= 1'b1;
        end else if (inp_cmd) begin
            fgi  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= P_IDLE;
            outr  <= 8'h00;
            cnt   <= 8'h00;
            fgo   <= 1'b1;
        end else begin
            state <= state_nxt;
            outr  <= outr_nxt;
            cnt   <= cnt_nxt;
            fgo   <= fgo_nxt;
        end
    end

    // FGO is high exactly while idle, so an OUT with fgo=0 is simply dropped.
    always_comb begin
        state_nxt = state;
        outr_nxt  = outr;
        cnt_nxt   = cnt;
        fgo_nxt   = fgo;
        prn_valid = 1'b0;
        case (state)
            P_IDLE: begin
                if (out_cmd && fgo) begin
                    outr_nxt  = ac_low;
                    fgo_nxt   = 1'b0;
                    state_nxt = P_SEND;
                end
            end
            P_SEND: begin
                prn_valid = 1'b1;
                if (prn_ready) begin
                    if (PRN_HOLDOFF == 0) begin
                        fgo_nxt   = 1'b1;
                        state_nxt = P_IDLE;
                    end else begin
                        cnt_nxt   = 8'(PRN_HOLDOFF);
                        state_nxt = P_BUSY;
                    end
                end
            end
            P_BUSY: begin
                cnt_nxt = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    cnt_nxt   = 8'h00;
                    fgo_nxt   = 1'b1;
                    state_nxt = P_IDLE;
                end
            end
            default: begin
                state_nxt = P_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_io_port.sv
// tb/tb_io_port.sv - randomized and directed checks of io_port against a behavioural model
module tb_io_port;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       io_exec, io_exec0;
    logic [3:0] io_op;
    logic [7:0] ac_low;
    logic [7:0] kbd_data;
    logic       kbd_valid;
    logic       prn_ready, prn_ready0;

    logic [7:0] inpr, prn_data;
    logic       ld_ac_inpr, skip, fgi, fgo, kbd_ready, prn_valid;
    logic [7:0] inpr0, prn_data0;
    logic       ld_ac_inpr0, skip0, fgi0, fgo0, kbd_ready0, prn_valid0;

    int tests = 0;
    int fails = 0;

    // behavioural model: registers plus "byte being offered" and "edges left before FGO"
    logic [7:0] m_inpr, m_outr;
    logic       m_fgi, m_fgo, m_send;
    int         m_wait;

    always #5 clk = ~clk;

    io_port #(.PRN_HOLDOFF(HOLD)) u_dut (
        .clk(clk), .rst(rst), .io_exec(io_exec), .io_op(io_op), .ac_low(ac_low),
        .inpr(inpr), .ld_ac_inpr(ld_ac_inpr), .skip(skip), .fgi(fgi), .fgo(fgo),
        .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
        .prn_data(prn_data), .prn_valid(prn_valid), .prn_ready(prn_ready)
    );

    io_port #(.PRN_HOLDOFF(0)) u_dut0 (
        .clk(clk), .rst(rst), .io_exec(io_exec0), .io_op(io_op), .ac_low(ac_low),
        .inpr(inpr0), .ld_ac_inpr(ld_ac_inpr0), .skip(skip0), .fgi(fgi0), .fgo(fgo0),
        .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready0),
        .prn_data(prn_data0), .prn_valid(prn_valid0), .prn_ready(prn_ready0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_inpr = 8'h00; m_outr = 8'h00;
        m_fgi = 1'b0; m_fgo = 1'b1; m_send = 1'b0; m_wait = 0;
    endtask

    task automatic idle_inputs();
        io_exec = 1'b0; io_exec0 = 1'b0; io_op = 4'h0; ac_low = 8'h00;
        kbd_data = 8'h00; kbd_valid = 1'b0; prn_ready = 1'b0; prn_ready0 = 1'b0;
    endtask

    // Inputs already driven (just after a negedge). Check everything, advance model, move to next negedge.
    task automatic step();
        logic xfer, inp, out_ok;
        #1;
        check("inpr", inpr, m_inpr);
        check("fgi", fgi, m_fgi);
        check("fgo", fgo, m_fgo);
        check("kbd_ready", kbd_ready, !m_fgi);
        check("prn_valid", prn_valid, m_send);
        check("prn_data", prn_data, m_outr);
        check("ld_ac_inpr", ld_ac_inpr, io_exec & io_op[3]);
        check("skip", skip, io_exec & ((io_op[1] & m_fgi) | (io_op[0] & m_fgo)));
        xfer   = kbd_valid && !m_fgi;
        inp    = io_exec && io_op[3];
        out_ok = io_exec && io_op[2] && m_fgo;
        if (xfer) begin
            m_inpr = kbd_data;
            m_fgi  = 1'b1;
        end else if (inp) begin
            m_fgi = 1'b0;
        end
        if (m_send && prn_ready) begin
            m_send = 1'b0;
            if (HOLD == 0) m_fgo = 1'b1;
            else m_wait = HOLD;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_fgo = 1'b1;
        end
        if (out_ok) begin
            m_outr = ac_low;
            m_fgo  = 1'b0;
            m_send = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // keyboard byte then SKI and INP
        kbd_valid = 1'b1; kbd_data = 8'hA5;
        step();
        kbd_valid = 1'b0;
        #1;
        check("kbd_fgi", fgi, 1'b1);
        check("kbd_ready_low", kbd_ready, 1'b0);
        io_exec = 1'b1; io_op = 4'b0010;
        #1;
        check("ski_skip", skip, 1'b1);
        step();
        io_op = 4'b1000;
        #1;
        check("inp_ld", ld_ac_inpr, 1'b1);
        check("inp_data", inpr, 8'hA5);
        step();
        io_exec = 1'b0; io_op = 4'h0;
        #1;
        check("inp_clr_fgi", fgi, 1'b0);

        // OUT with holdoff, printer stalls, OUT while busy ignored
        io_exec = 1'b1; io_op = 4'b0100; ac_low = 8'h3C;
        step();
        io_exec = 1'b0;
        #1;
        check("out_fgo", fgo, 1'b0);
        check("out_valid", prn_valid, 1'b1);
        check("out_data", prn_data, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin io_exec = 1'b1; io_op = 4'b0100; ac_low = 8'h11; end
            else io_exec = 1'b0;
            step();
            check("stall_data", prn_data, 8'h3C);
            check("stall_valid", prn_valid, 1'b1);
        end
        io_exec = 1'b0;
        prn_ready = 1'b1;
        step();
        prn_ready = 1'b0;
        check("hs_valid_drop", prn_valid, 1'b0);
        for (int e = 2; e <= HOLD + 1; e++) begin
            io_exec = 1'b1; io_op = (e == 3) ? 4'b0100 : 4'b0001; ac_low = 8'h11;
            #1;
            check("busy_fgo", fgo, 1'b0);
            if (e != 3) check("sko_busy", skip, 1'b0);
            step();
            check("busy_no_pulse", prn_valid, 1'b0);
            check("busy_outr", prn_data, 8'h3C);
        end
        io_exec = 1'b0; io_op = 4'h0;
        #1;
        check("fgo_after_holdoff", fgo, 1'b1);

        // simultaneous keyboard byte and INP, then INP+OUT together
        kbd_valid = 1'b1; kbd_data = 8'h7E; io_exec = 1'b1; io_op = 4'b1000;
        step();
        kbd_valid = 1'b0; io_exec = 1'b0;
        #1;
        check("simul_fgi", fgi, 1'b1);
        check("simul_inpr", inpr, 8'h7E);
        io_exec = 1'b1; io_op = 4'b1100; ac_low = 8'h9A;
        #1;
        check("combo_ld", ld_ac_inpr, 1'b1);
        step();
        io_exec = 1'b0; io_op = 4'h0;
        #1;
        check("combo_fgi", fgi, 1'b0);
        check("combo_fgo", fgo, 1'b0);
        check("combo_data", prn_data, 8'h9A);
        prn_ready = 1'b1;
        step();
        prn_ready = 1'b0;
        repeat (HOLD + 1) step();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            io_exec   = ($urandom_range(0, 99) < 40);
            io_op     = 4'($urandom);
            ac_low    = 8'($urandom);
            kbd_valid = ($urandom_range(0, 99) < 30);
            kbd_data  = 8'($urandom);
            prn_ready = ($urandom_range(0, 99) < 40);
            step();
        end

        // asynchronous reset in the middle of a printer handshake
        idle_inputs();
        prn_ready = 1'b1;
        for (int k = 0; k < 12 && !m_fgo; k++) step();
        check("drain_bound", m_fgo, 1'b1);
        prn_ready = 1'b0;
        kbd_valid = 1'b1; kbd_data = 8'hC3;
        io_exec = 1'b1; io_op = 4'b0100; ac_low = 8'hE7;
        step();
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        check("rst_fgi", fgi, 1'b0);
        check("rst_fgo", fgo, 1'b1);
        check("rst_inpr", inpr, 8'h00);
        check("rst_prn_valid", prn_valid, 1'b0);
        check("rst_kbd_ready", kbd_ready, 1'b1);
        check("rst_prn_data", prn_data, 8'h00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step();

        // zero-holdoff build: FGO returns on the handshake edge itself
        #1;
        check("h0_fgo_idle", fgo0, 1'b1);
        io_exec0 = 1'b1; io_op = 4'b0100; ac_low = 8'h5A;
        step();
        io_exec0 = 1'b0; io_op = 4'h0;
        #1;
        check("h0_valid", prn_valid0, 1'b1);
        check("h0_fgo_low", fgo0, 1'b0);
        check("h0_data", prn_data0, 8'h5A);
        prn_ready0 = 1'b1;
        step();
        prn_ready0 = 1'b0;
        #1;
        check("h0_fgo_set", fgo0, 1'b1);
        check("h0_valid_drop", prn_valid0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
